// File: rtl/fifo_block_reader.sv
// Pops bytes from a one-cycle-latency synchronous FIFO and packs them into
// BYTES_PER_BLOCK-byte blocks presented to the cipher core over valid/ready.
module fifo_block_reader #(
  parameter int unsigned BYTES_PER_BLOCK = 8,
  parameter bit          LSB_FIRST       = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [7:0]                               fifo_dout,
  input  logic                                     fifo_empty,
  input  logic                                     fifo_rd_rst_busy,
  output logic                                     fifo_rd_en,
  input  logic                                     flush,
  output logic [8*BYTES_PER_BLOCK-1:0]             blk_data,
  output logic                                     blk_valid,
  input  logic                                     blk_ready,
  output logic [$clog2(BYTES_PER_BLOCK+1)-1:0]     fill_level
);

  localparam int unsigned FW = $clog2(BYTES_PER_BLOCK + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] issue_q, issue_d;
  logic [FW-1:0] fill_d;
  logic          pend_q, pend_d;
  logic          valid_d;
  logic          capture;
  logic [FW-1:0] lane;

  // Byte lane that the returning byte lands in
  assign lane = LSB_FIRST ? fill_level : (FW'(BYTES_PER_BLOCK - 1) - fill_level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      issue_q    <= '0;
      fill_level <= '0;
      pend_q     <= 1'b0;
      blk_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      fill_level <= fill_d;
      pend_q     <= pend_d;
      blk_valid  <= valid_d;
    end
  end

  // Next state, counters and pop strobe; flush overrides everything
  always_comb begin
    state_d    = state_q;
    issue_d    = issue_q;
    fill_d     = fill_level;
    pend_d     = 1'b0;
    valid_d    = blk_valid;
    capture    = 1'b0;
    fifo_rd_en = 1'b0;
    if (flush) begin
      state_d = FILL;
      issue_d = '0;
      fill_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          fifo_rd_en = rst_n && (issue_q < FW'(BYTES_PER_BLOCK)) &&
                       !fifo_empty && !fifo_rd_rst_busy;
          if (fifo_rd_en) begin
            issue_d = issue_q + FW'(1);
          end
          pend_d = fifo_rd_en;
          if (pend_q) begin
            capture = 1'b1;
            fill_d  = fill_level + FW'(1);
            if (fill_level == FW'(BYTES_PER_BLOCK - 1)) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (blk_ready) begin
            state_d = FILL;
            valid_d = 1'b0;
            issue_d = '0;
            fill_d  = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Block assembly register; untouched lanes keep their previous contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_data <= '0;
    end else if (capture) begin
      for (int i = 0; i < int'(BYTES_PER_BLOCK); i++) begin
        if (lane == FW'(i)) begin
          blk_data[8*i +: 8] <= fifo_dout;
        end
      end
    end
  end

endmodule
